// File: rtl/cdb_arbiter_if.sv
// FU writeback handshake and CDB slot bundle for cdb_arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_FU    = 4,
  parameter int unsigned CDB_PORTS = 2,
  parameter int unsigned ROB_ID_W  = 3,
  parameter int unsigned PREG_W    = 6
);

  logic [NUM_FU-1:0]                fu_valid;
  logic [NUM_FU-1:0]                fu_ready;
  logic [NUM_FU-1:0][ROB_ID_W-1:0]  fu_rob_id;
  logic [NUM_FU-1:0][PREG_W-1:0]    fu_phys_rd;
  logic [NUM_FU-1:0][31:0]          fu_value;
  logic [NUM_FU-1:0]                fu_branch_result;

  logic [CDB_PORTS-1:0]               cdb_valid;
  logic [CDB_PORTS-1:0][ROB_ID_W-1:0] cdb_rob_id;
  logic [CDB_PORTS-1:0][PREG_W-1:0]   cdb_phys_rd;
  logic [CDB_PORTS-1:0][31:0]         cdb_value;
  logic [CDB_PORTS-1:0]               cdb_branch_result;

  modport master (
    output fu_valid, fu_rob_id, fu_phys_rd, fu_value, fu_branch_result,
    input  fu_ready,
    input  cdb_valid, cdb_rob_id, cdb_phys_rd, cdb_value, cdb_branch_result
  );

  modport slave (
    input  fu_valid, fu_rob_id, fu_phys_rd, fu_value, fu_branch_result,
    output fu_ready,
    output cdb_valid, cdb_rob_id, cdb_phys_rd, cdb_value, cdb_branch_result
  );

endinterface

// File: rtl/cdb_arbiter.sv
// CDB transmitter: per-FU result FIFOs, round-robin grant of CDB_PORTS registered slots.
// Define CDB_BYPASS_EN to let an empty FU be granted straight from its inputs (latency 1).
module cdb_arbiter #(
  parameter int unsigned NUM_FU     = 4,
  parameter int unsigned CDB_PORTS  = 2,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ROB_DEPTH  = 8,
  parameter int unsigned PREG_W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);

  localparam int unsigned ROB_ID_W = $clog2(ROB_DEPTH);
  localparam int unsigned FU_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [PREG_W-1:0]   phys_rd;
    logic [31:0]         value;
    logic                br;
  } res_t;

  res_t             mem_q    [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_FU];
  logic [PTR_W-1:0] wr_ptr_d [NUM_FU];
  logic [PTR_W-1:0] rd_ptr_q [NUM_FU];
  logic [PTR_W-1:0] rd_ptr_d [NUM_FU];
  logic [CNT_W-1:0] cnt_q    [NUM_FU];
  logic [CNT_W-1:0] cnt_d    [NUM_FU];
  logic [FU_W-1:0]  rr_q, rr_d;
  logic             alive_q;

  logic [CDB_PORTS-1:0] out_vld_q, out_vld_d;
  res_t                 out_res_q [CDB_PORTS];
  res_t                 out_res_d [CDB_PORTS];

  res_t                 in_res   [NUM_FU];
  res_t                 src      [NUM_FU];
  res_t                 slot_res [CDB_PORTS];
  logic [CDB_PORTS-1:0] slot_vld;
  logic [NUM_FU-1:0]    nonempty, ready, cand, grant, push, pop;
  logic [FU_W-1:0]      last_fu;

  always_comb begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      in_res[i].rob_id  = bus.fu_rob_id[i];
      in_res[i].phys_rd = bus.fu_phys_rd[i];
      in_res[i].value   = bus.fu_value[i];
      in_res[i].br      = bus.fu_branch_result[i];
      nonempty[i]       = (cnt_q[i] != '0);
      // alive_q keeps ready low from reset assertion until the first edge after release
      ready[i]          = alive_q && (cnt_q[i] < CNT_W'(FIFO_DEPTH));
`ifdef CDB_BYPASS_EN
      cand[i] = nonempty[i] || (bus.fu_valid[i] && ready[i]);
      src[i]  = nonempty[i] ? mem_q[i][rd_ptr_q[i]] : in_res[i];
`else
      cand[i] = nonempty[i];
      src[i]  = mem_q[i][rd_ptr_q[i]];
`endif
    end
  end

  // Scan from rr_q; each candidate takes the lowest free slot, so slots fill in scan order.
  always_comb begin
    logic [FU_W-1:0] idx;
    logic            taken;
    grant    = '0;
    slot_vld = '0;
    last_fu  = rr_q;
    idx      = '0;
    taken    = 1'b0;
    for (int unsigned s = 0; s < CDB_PORTS; s++) slot_res[s] = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      idx   = FU_W'((32'(rr_q) + k) % NUM_FU);
      taken = 1'b0;
      for (int unsigned s = 0; s < CDB_PORTS; s++) begin
        if (cand[idx] && !taken && !slot_vld[s]) begin
          slot_vld[s] = 1'b1;
          slot_res[s] = src[idx];
          grant[idx]  = 1'b1;
          last_fu     = idx;
          taken       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      push[i] = bus.fu_valid[i] && ready[i] && !flush;
`ifdef CDB_BYPASS_EN
      push[i] = push[i] && !(grant[i] && !nonempty[i]);
`endif
      pop[i]      = grant[i] && nonempty[i] && !flush;
      wr_ptr_d[i] = flush ? '0 : wr_ptr_q[i] + PTR_W'(push[i]);
      rd_ptr_d[i] = flush ? '0 : rd_ptr_q[i] + PTR_W'(pop[i]);
      cnt_d[i]    = flush ? '0 : cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end

    if (flush)       rr_d = '0;
    else if (|grant) rr_d = FU_W'((32'(last_fu) + 1) % NUM_FU);
    else             rr_d = rr_q;

    out_vld_d = flush ? '0 : slot_vld;
    for (int unsigned s = 0; s < CDB_PORTS; s++)
      out_res_d[s] = (slot_vld[s] && !flush) ? slot_res[s] : out_res_q[s];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      for (int unsigned s = 0; s < CDB_PORTS; s++) out_res_q[s] <= '0;
      rr_q      <= '0;
      out_vld_q <= '0;
      alive_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      for (int unsigned s = 0; s < CDB_PORTS; s++) out_res_q[s] <= out_res_d[s];
      rr_q      <= rr_d;
      out_vld_q <= out_vld_d;
      alive_q   <= 1'b1;
    end
  end

  // Entry storage needs no reset: only slots covered by cnt_q are ever granted.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_FU; i++)
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_res[i];
  end

  always_comb begin
    bus.fu_ready  = ready;
    bus.cdb_valid = out_vld_q;
    for (int unsigned s = 0; s < CDB_PORTS; s++) begin
      bus.cdb_rob_id[s]        = out_res_q[s].rob_id;
      bus.cdb_phys_rd[s]       = out_res_q[s].phys_rd;
      bus.cdb_value[s]         = out_res_q[s].value;
      bus.cdb_branch_result[s] = out_res_q[s].br;
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Transmitter side of the common data bus (CDB). It collects writeback results from NUM_FU functional units over per-unit valid/ready handshakes and buffers each unit in a small FIFO. Each cycle it grants up to CDB_PORTS results, round-robin, and drives them as registered CDB slots that the parent packs into cdb_t for the ROB, reservation stations and physical register file. On a ROB flush it discards all buffered results.

Parameters:
NUM_FU, 4, number of functional-unit result sources
CDB_PORTS, 2, CDB slots driven per cycle (matches CDB)
FIFO_DEPTH, 2, entries per FU buffer (power of two, >=2)
ROB_DEPTH, 8, ROB entries; ROB_ID_W = $clog2(ROB_DEPTH)
PREG_W, 6, physical register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  ROB mispredict flush, synchronous
fu_valid  in  [NUM_FU] x 1  FU result valid
fu_ready  out  [NUM_FU] x 1  arbiter can accept from FU
fu_rob_id  in  [NUM_FU] x ROB_ID_W  ROB entry of result
fu_phys_rd  in  [NUM_FU] x PREG_W  destination physical register
fu_value  in  [NUM_FU] x 32  result value
fu_branch_result  in  [NUM_FU] x 1  branch/jump taken
cdb_valid  out  [CDB_PORTS] x 1  slot carries result (ready_for_writeback)
cdb_rob_id  out  [CDB_PORTS] x ROB_ID_W
cdb_phys_rd  out  [CDB_PORTS] x PREG_W
cdb_value  out  [CDB_PORTS] x 32
cdb_branch_result  out  [CDB_PORTS] x 1

Behaviour:
- Reset (rst=0, async): all FIFOs empty, rr_ptr=0, all cdb_* outputs 0, fu_ready all 0 while rst low. fu_ready is 1 from the first cycle after deassertion.
- Handshake: a transfer occurs on a clk edge where fu_valid[i] && fu_ready[i]. fu_ready[i] = (registered count[i] < FIFO_DEPTH). There is no combinational path from pop to ready: a full FIFO shows ready=0 even in a cycle it is popped.
- FIFO: per FU, pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1. A simultaneous push and pop leaves the count unchanged.
- Arbitration (combinational, each cycle):
  - Scan FU indices rr_ptr, rr_ptr+1, ... modulo NUM_FU.
  - Grant the first min(CDB_PORTS, #non-empty) non-empty FIFOs, at most one grant per FU per cycle.
  - Grants are assigned to slots 0.. in scan order.
  - Each granted FIFO pops its head at the edge.
- rr_ptr update: if any grant occurs, rr_ptr <= (index of last granted FU + 1) mod NUM_FU. With no grants, rr_ptr holds.
- Output register: slot k is loaded with the k-th granted head, with cdb_valid[k]=1. Unused slots get cdb_valid=0 and their data fields are held (don't-care).
- Latency: a result accepted at edge t is in the FIFO during cycle t+1. If granted, it appears on the CDB in cycle t+2. With CDB_BYPASS_EN, see below.
- Ordering: results from one FU leave in acceptance order. There is no ordering guarantee across FUs.
- Throughput: sustained CDB_PORTS results per cycle while enough FIFOs are non-empty.
- Flush: at the edge where flush=1:
  - all FIFOs are emptied, rr_ptr <= 0 and all cdb_valid <= 0;
  - fu_valid pushes in that cycle are discarded;
  - grants made in that cycle are not issued.
  - fu_ready follows the emptied counts from the next cycle.
- Reset mid-operation: all buffered and in-flight results are lost immediately. Outputs go to their reset values asynchronously.
- Widths: rob_id and phys_rd pass through unchanged. No arithmetic is performed on data fields.

Optional Feature:
CDB_BYPASS_EN:
- Defined: an FU whose FIFO is empty, presenting fu_valid=1, may be granted in the same cycle. It joins the round-robin scan as if its FIFO were non-empty. The result goes straight to the output register (latency 1, cycle t+1) without being written into the FIFO.
- Not defined: all results pass through the FIFO, minimum latency 2.
- Flush and fu_ready semantics are identical in both builds.

Test Plan:
- Reset release, no fu_valid for 5 cycles -> cdb_valid=00, fu_ready=1111, every cycle.
- FU2 pushes rob_id=5, value=0xDEADBEEF at edge t -> cycle t+2: cdb_valid[0]=1, rob_id=5, value=0xDEADBEEF, cdb_valid[1]=0 (t+1 with CDB_BYPASS_EN).
- All 4 FUs push one result each in the same cycle, rr_ptr=0 -> next grant cycle FU0/FU1 on slots 0/1, following cycle FU2/FU3, rr_ptr ends at 0.
- FU1 pushes 3 back-to-back with no grants possible (FIFO_DEPTH=2, other FUs saturating) -> fu_ready[1]=0 after 2 accepts, third held until a pop, per-FU order 1,2,3 preserved on the CDB.
- Flush asserted while FIFOs hold 5 results and FU3 pushes -> next cycle cdb_valid=00, all counts 0, FU3's result never appears.
- rst driven low mid-burst, asynchronous to clk -> cdb_valid=00 and fu_ready=0000 before the next edge, no stale result after release.
